// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the 3x3 convolution feeder.
package conv_pkg;
    localparam int IMG_W          = 50;
    localparam int OUT_W          = IMG_W - 2;
    localparam int N_GROUPS       = 16;
    localparam int WIN_ROWS       = 5;
    localparam int ROWS_PER_GROUP = 3;
    localparam int N_WBYTES       = 9;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        LOAD_ROWS,
        EMIT
    } state_t;
endpackage

// File: rtl/conv_rowbuf.sv
// Five-row circular pixel store: one byte write port, five 3-byte reads at a shared column.
module conv_rowbuf
    import conv_pkg::*;
#(
    parameter int IMG_W = conv_pkg::IMG_W,
    parameter int CW    = $clog2(IMG_W)
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [2:0]                 wslot,
    input  logic [CW-1:0]              wcol,
    input  logic [7:0]                 wbyte,
    input  logic [CW-1:0]              rcol,
    output logic [WIN_ROWS-1:0][23:0]  rdata
);
    logic [7:0] mem [WIN_ROWS][IMG_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wslot][wcol] <= wbyte;
        end
    end

    for (genvar k = 0; k < WIN_ROWS; k++) begin : g_rd
        assign rdata[k] = {mem[k][rcol], mem[k][rcol + CW'(1)], mem[k][rcol + CW'(2)]};
    end
endmodule

// File: rtl/conv_feeder.sv
// AXI-Stream frame parser: loads a 3x3 kernel, buffers rows and streams 5-row pixel windows.
module conv_feeder
    import conv_pkg::*;
#(
    parameter int IMG_W    = conv_pkg::IMG_W,
    parameter int N_GROUPS = conv_pkg::N_GROUPS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    input  logic        conv_busy,
    output logic [71:0] wdata,
    output logic        wdata_valid,
    output logic [23:0] pdata1,
    output logic [23:0] pdata2,
    output logic [23:0] pdata3,
    output logic [23:0] pdata4,
    output logic [23:0] pdata5,
    output logic        pdata_valid,
    output logic        frame_done,
    output logic        frame_err
);
    localparam int CW      = $clog2(IMG_W);
    localparam int GW      = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam int OUT_LEN = IMG_W - 2;

    state_t               state;
    logic [3:0]           wcnt;
    logic [CW-1:0]        col;
    logic [2:0]           row_cnt;
    logic [GW-1:0]        grp;
    logic [2:0]           wslot;
    logic [2:0]           rbase;
    logic                 tlast_missing;
    logic [WIN_ROWS-1:0][23:0] rd;

    logic beat, row_end, group_end, last_group;

    function automatic logic [2:0] slot_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 4'(WIN_ROWS)) ? 3'(s - 4'(WIN_ROWS)) : s[2:0];
    endfunction

    // Ready is a pure function of state, so it never combinationally follows tvalid.
    assign s_axis_tready = (state == LOAD_W) || (state == LOAD_ROWS);
    assign beat          = s_axis_tvalid && s_axis_tready;
    assign row_end       = (col == CW'(IMG_W - 1));
    assign group_end     = row_end &&
                           (row_cnt == ((grp == '0) ? 3'(WIN_ROWS - 1) : 3'(ROWS_PER_GROUP - 1)));
    assign last_group    = (grp == GW'(N_GROUPS - 1));

    conv_rowbuf #(.IMG_W(IMG_W), .CW(CW)) u_rowbuf (
        .clk   (clk),
        .we    (beat && (state == LOAD_ROWS)),
        .wslot (wslot),
        .wcol  (col),
        .wbyte (s_axis_tdata),
        .rcol  ((state == EMIT) ? col : '0),
        .rdata (rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wcnt          <= '0;
            col           <= '0;
            row_cnt       <= '0;
            grp           <= '0;
            wslot         <= '0;
            rbase         <= '0;
            tlast_missing <= 1'b0;
            wdata         <= '0;
            wdata_valid   <= 1'b0;
            pdata1        <= '0;
            pdata2        <= '0;
            pdata3        <= '0;
            pdata4        <= '0;
            pdata5        <= '0;
            pdata_valid   <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            wdata_valid <= 1'b0;
            pdata_valid <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    wcnt          <= '0;
                    col           <= '0;
                    row_cnt       <= '0;
                    grp           <= '0;
                    wslot         <= '0;
                    rbase         <= '0;
                    tlast_missing <= 1'b0;
                    if (!conv_busy) state <= LOAD_W;
                end
                LOAD_W: begin
                    if (beat) begin
                        // Shifting in from the bottom leaves byte 0 in [71:64] after nine beats.
                        wdata <= {wdata[63:0], s_axis_tdata};
                        wcnt  <= wcnt + 4'd1;
                        if (s_axis_tlast) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else if (wcnt == 4'(N_WBYTES - 1)) begin
                            wdata_valid <= 1'b1;
                            state       <= LOAD_ROWS;
                        end
                    end
                end
                LOAD_ROWS: begin
                    if (beat) begin
                        if (row_end) begin
                            col     <= '0;
                            wslot   <= slot_add(wslot, 3'd1);
                            row_cnt <= group_end ? 3'd0 : row_cnt + 3'd1;
                        end else begin
                            col <= col + CW'(1);
                        end
                        if (s_axis_tlast && !(group_end && last_group)) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else if (group_end) begin
                            tlast_missing <= last_group && !s_axis_tlast;
                            state         <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    // Window row K of group g lives in slot (3g + K) mod 5; rbase tracks 3g mod 5.
                    pdata_valid <= 1'b1;
                    pdata1      <= rd[slot_add(rbase, 3'd0)];
                    pdata2      <= rd[slot_add(rbase, 3'd1)];
                    pdata3      <= rd[slot_add(rbase, 3'd2)];
                    pdata4      <= rd[slot_add(rbase, 3'd3)];
                    pdata5      <= rd[slot_add(rbase, 3'd4)];
                    if (col == CW'(OUT_LEN - 1)) begin
                        col   <= '0;
                        grp   <= grp + GW'(1);
                        rbase <= slot_add(rbase, 3'(ROWS_PER_GROUP));
                        if (last_group) begin
                            frame_done <= 1'b1;
                            frame_err  <= tlast_missing;
                            state      <= IDLE;
                        end else begin
                            state <= LOAD_ROWS;
                        end
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
